// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO pair: radix-2 shift-add multiply and
// restoring divide, one bit per cycle, with single-cycle MTHI/MTLO writes.
module mul_div_unit #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            opcode,
  input  logic [WORD_WIDTH-1:0] a_input,
  input  logic [WORD_WIDTH-1:0] b_input,
  output logic                  busy,
  output logic                  done,
  output logic [WORD_WIDTH-1:0] hi,
  output logic [WORD_WIDTH-1:0] lo
);
  localparam int W  = WORD_WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic            is_div_q, is_div_d;
  logic            neg_lo_q, neg_lo_d;
  logic            neg_hi_q, neg_hi_d;
  logic [W-1:0]    opnd_q, opnd_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    lo_q, lo_d;
  logic            done_q, done_d;

  logic            a_neg, b_neg;
  logic [W-1:0]    a_mag, b_mag;
  logic [W:0]      mul_sum;
  logic [W:0]      div_shift;
  logic [W:0]      div_diff;
  logic [2*W-1:0]  acc_neg;

  // Opcodes 000/010 are the signed forms; magnitudes are taken before iterating.
  assign a_neg = ~opcode[0] & a_input[W-1];
  assign b_neg = ~opcode[0] & b_input[W-1];
  assign a_mag = a_neg ? -a_input : a_input;
  assign b_mag = b_neg ? -b_input : b_input;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  assign mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
  // Divide: acc = {partial remainder, remaining dividend bits / quotient bits}, shifted left.
  assign div_shift = acc_q[2*W-1:W-1];
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign acc_neg   = -acc_q;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (!opcode[2]) begin
            count_d  = '0;
            is_div_d = opcode[1];
            neg_lo_d = a_neg ^ b_neg;
            neg_hi_d = a_neg;
            state_d  = RUN;
            if (opcode[1]) begin
              opnd_d = b_mag;
              acc_d  = {{W{1'b0}}, a_mag};
            end else begin
              opnd_d = a_mag;
              acc_d  = {{W{1'b0}}, b_mag};
            end
            // Divide by zero bypasses RUN; FIX then passes the raw dividend through.
            if (opcode[1] && (b_input == '0)) begin
              acc_d    = {a_input, {W{1'b1}}};
              neg_lo_d = 1'b0;
              neg_hi_d = 1'b0;
              state_d  = FIX;
            end
          end else if (!opcode[1]) begin
            if (opcode[0]) lo_d = a_input;
            else           hi_d = a_input;
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        count_d = count_q + 1'b1;
        if (count_q == CW'(W-1)) state_d = FIX;
        if (!is_div_q) begin
          acc_d = {mul_sum, acc_q[W-1:1]};
        end else if (!div_diff[W]) begin
          acc_d = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
        end else begin
          acc_d = {div_shift[W-1:0], acc_q[W-2:0], 1'b0};
        end
      end
      FIX: begin
        if (is_div_q) begin
          lo_d = neg_lo_q ? -acc_q[W-1:0]   : acc_q[W-1:0];
          hi_d = neg_hi_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
        end else begin
          {hi_d, lo_d} = neg_lo_q ? acc_neg : acc_q;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes expected HI/LO and busy length,
// a negedge monitor pops on every done pulse and checks HI/LO hold otherwise.
module tb_mul_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   opcode = 3'd0;
  logic [W-1:0] a_input = '0;
  logic [W-1:0] b_input = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  mul_div_unit #(.WORD_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .a_input(a_input), .b_input(b_input),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           lat;
  } exp_t;

  exp_t         sb_q[$];
  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] model_hi = '0, model_lo = '0;
  logic [W-1:0] commit_hi = '0, commit_lo = '0;
  int           busy_cnt = 0;
  logic         rst_seen = 1'b1;

  always @(posedge clk) rst_seen <= reset;

  // Behavioural reference: plain 64-bit arithmetic on the architectural definitions.
  function automatic void ref_model(input logic [2:0] op, input logic [W-1:0] a, b,
                                    input logic [W-1:0] h_in, l_in,
                                    output logic [W-1:0] h, l, output int lat, output bit prod);
    longint sa, sb, sq, sr;
    logic [63:0] p;
    h = h_in; l = l_in; lat = W + 1; prod = 1'b1;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
      3'd1: begin p = {32'b0, a} * {32'b0, b}; h = p[63:32]; l = p[31:0]; end
      3'd2: if (b == 0) begin h = a; l = '1; lat = 1; end
            else begin sq = sa / sb; sr = sa % sb; l = sq[31:0]; h = sr[31:0]; end
      3'd3: if (b == 0) begin h = a; l = '1; lat = 1; end
            else begin l = a / b; h = a % b; end
      3'd4: begin h = a; lat = 0; end
      3'd5: begin l = a; lat = 0; end
      default: prod = 1'b0;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_seen) begin
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
        failures++;
        $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, required all zero", busy, done, hi, lo);
      end
      commit_hi = '0; commit_lo = '0; busy_cnt = 0;
    end else begin
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done: hi=%h lo=%h, required no done pulse", hi, lo);
          commit_hi = hi; commit_lo = lo;
        end else begin
          e = sb_q.pop_front();
          if (hi !== e.hi || lo !== e.lo) begin
            failures++;
            $display("FAIL result op=%0d: hi=%h lo=%h, required hi=%h lo=%h", e.op, hi, lo, e.hi, e.lo);
          end
          checks++;
          if (busy_cnt != e.lat) begin
            failures++;
            $display("FAIL busy_length op=%0d: %0d cycles, required %0d", e.op, busy_cnt, e.lat);
          end
          $display("txn op=%0d hi=%h lo=%h busy_cycles=%0d", e.op, hi, lo, busy_cnt);
          commit_hi = e.hi; commit_lo = e.lo;
        end
        busy_cnt = 0;
      end else begin
        checks++;
        if (hi !== commit_hi || lo !== commit_lo) begin
          failures++;
          $display("FAIL hold: hi=%h lo=%h, required hi=%h lo=%h", hi, lo, commit_hi, commit_lo);
          commit_hi = hi; commit_lo = lo;
        end
      end
    end
  end

  task automatic wait_idle();
    int guard = 0;
    while (busy !== 1'b0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_timeout: busy=%b after %0d cycles, required 0", busy, guard);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, b);
    exp_t e;
    int lat;
    bit prod;
    logic [W-1:0] h, l;
    wait_idle();
    ref_model(op, a, b, model_hi, model_lo, h, l, lat, prod);
    if (prod) begin
      model_hi = h; model_lo = l;
      e.op = op; e.hi = h; e.lo = l; e.lat = lat;
      sb_q.push_back(e);
    end
    start = 1'b1; opcode = op; a_input = a; b_input = b;
    @(posedge clk); #1;
    start = 1'b0;
    a_input = $urandom; b_input = $urandom;
  endtask

  task automatic poke_busy_start(input logic [2:0] op, input logic [W-1:0] a, b);
    start = 1'b1; opcode = op; a_input = a; b_input = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    sb_q.delete();
    model_hi = '0; model_lo = '0;
    repeat (cycles) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    int guard;
    @(posedge clk); #1;
    do_reset(2);
    repeat (2) @(posedge clk); #1;

    issue(3'd0, 32'hFFFF_FFFF, 32'h0000_0002);
    issue(3'd1, 32'hFFFF_FFFF, 32'h0000_0002);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    issue(3'd3, 32'd7, 32'd2);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(3'd3, 32'h0000_1234, 32'd0);
    issue(3'd2, 32'hFFFF_FFF0, 32'd0);

    issue(3'd0, 32'h0001_2345, 32'hFFFF_0003);
    repeat (4) @(posedge clk);
    #1 poke_busy_start(3'd3, 32'd100, 32'd7);
    issue(3'd5, 32'hA5A5_A5A5, 32'd0);
    issue(3'd4, 32'h5A5A_5A5A, 32'd0);
    issue(3'd6, 32'hDEAD_BEEF, 32'd1);
    issue(3'd7, 32'hDEAD_BEEF, 32'd1);
    repeat (3) @(posedge clk); #1;

    issue(3'd2, 32'h7654_3210, 32'd9);
    repeat (9) @(posedge clk);
    #1 do_reset(1);
    repeat (40) @(posedge clk); #1;
    issue(3'd0, 32'h8000_0000, 32'h8000_0000);

    for (int i = 0; i < 150; i++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick());
      if ($urandom_range(0, 5) == 0) begin
        #0;
        if (busy === 1'b1) poke_busy_start(3'($urandom_range(0, 5)), pick(), pick());
      end
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    guard = 0;
    while (sb_q.size() != 0 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d results outstanding, required 0", sb_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit that sits beside the combinational ALU in the EX stage and owns the HI/LO register pair. It executes signed/unsigned multiply and divide over a parametrised word width in WORD_WIDTH+1 cycles using a start/busy/done handshake, and services MTHI/MTLO writes in a single cycle. The pipeline stalls on `busy` and reads results from `hi`/`lo`.

## Interface
- WORD_WIDTH, 32: operand and HI/LO width; must be ≥ 4.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high; clears all state.
- start  input  1  request; sampled only while `busy`=0.
- opcode  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 reserved.
- a_input  input  WORD_WIDTH  multiplicand / dividend / MTHI/MTLO source.
- b_input  input  WORD_WIDTH  multiplier / divisor.
- busy  output  1  operation in progress; new starts ignored.
- done  output  1  one-cycle pulse: HI/LO updated at the previous edge.
- hi  output  WORD_WIDTH  HI register (product upper half / remainder).
- lo  output  WORD_WIDTH  LO register (product lower half / quotient).

## Operation
- States: IDLE, RUN, FIX.
- IDLE, start=1, opcode MULT/MULTU/DIV/DIVU, divisor ≠ 0 or multiply: latch operands and opcode, busy←1, count←0, go to RUN.
- Signed ops (MULT, DIV): operands converted to magnitudes at latch time; result sign recorded (product: sign a XOR sign b; quotient: sign a XOR sign b; remainder: sign a).
- RUN, multiply: radix-2 shift-add, one multiplier bit per cycle, 2·WORD_WIDTH accumulator.
- RUN, divide: restoring division, one quotient bit per cycle, WORD_WIDTH+1-bit partial remainder.
- RUN lasts exactly WORD_WIDTH cycles, then FIX.
- FIX: apply two's-complement correction for signed ops; write hi/lo; done←1; busy←0; go to IDLE.
- Multiply: {hi, lo} = full 2·WORD_WIDTH product.
- Divide: lo = quotient, hi = remainder, truncation toward zero.
- DIV of most-negative by −1: lo = most-negative (wraps), hi = 0; no flag.
- Divide by zero (DIV or DIVU, b_input = 0): skip RUN, go straight to FIX; hi = a_input, lo = all ones.
- MTHI / MTLO in IDLE: write hi / lo from a_input at the sampling edge; done←1 next cycle; busy stays 0; other register unchanged.
- Reserved opcodes: ignored entirely, no done.
- start while busy=1: ignored; operands and opcode not re-latched.
- hi/lo hold their previous values throughout RUN; updated only in FIX or by MTHI/MTLO.

## Timing
- Reset values: busy=0, done=0, hi=0, lo=0, state IDLE.
- Reset mid-operation: abort at that edge; no result written; all outputs return to reset values.
- Multiply/divide: start sampled at edge 0; busy=1 after edge 0; RUN on edges 1..WORD_WIDTH; FIX at edge WORD_WIDTH+1 writes hi/lo, sets done=1 and busy=0. Latency is WORD_WIDTH+1 edges (33 for 32-bit).
- Divide by zero: FIX at edge 1; done=1 after edge 1.
- MTHI/MTLO: done=1 after edge 0; done clears at the next edge.
- done is never high for more than one cycle.
- A new start may be sampled in the same cycle that done is high; busy is already 0.

## Test plan
- MULT a=0xFFFFFFFF, b=0x00000002 -> after 33 edges: hi=0xFFFFFFFF, lo=0xFFFFFFFE, done pulses once, busy high for exactly 33 cycles.
- MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (−7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU a=7, b=2 -> lo=3, hi=1.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. Then DIVU a=0x1234, b=0 -> done after edge 1, hi=0x1234, lo=0xFFFFFFFF.
- MULT started, then a second start (DIVU) asserted at edge 5 -> ignored; MULT result unchanged. Then MTLO a=0xA5A5A5A5 -> lo updated at the sampling edge, hi unchanged, done 1 cycle, busy never set.
- reset asserted at edge 10 of a DIV -> busy=0, done=0, hi=lo=0 after that edge; no done pulse follows; a fresh MULT afterwards completes correctly.
